mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single synchronous memory/MMU port between two requesters.
- Port A is the CPU execution unit. Port B is a secondary bus master (DMA / video fetch).
- Port A has fixed priority, but port B is guaranteed service after STARVE_LIMIT consecutive denied cycles.
- Issues at most one access per cycle, pipelined, and routes each read's return-valid to the port that issued it.

Parameters:
- AW, 16, address width (byte address).
- DW, 16, data width.
- STARVE_LIMIT, 4, consecutive denied B-request cycles before B is forced to priority (range 1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A access request, held until a_ack.
- a_addr  in  AW  port A address.
- a_byte  in  1  port A byte access (1) / word access (0).
- a_we  in  1  port A write (1) / read (0).
- a_wdata  in  DW  port A write data.
- a_wait  out  1  combinational: a_req high and A not granted this cycle.
- a_ack  out  1  registered pulse: A's request was issued to memory.
- a_rvalid  out  1  registered: mem_in_data is A's read result this cycle.
- b_req, b_addr, b_byte, b_we, b_wdata, b_wait, b_ack, b_rvalid: same as the A ports, for port B.
- rdata  out  DW  combinational passthrough of mem_in_data (shared by both ports).
- mem_addr  out  AW  registered memory address.
- mem_byte_enable  out  1  registered byte-op select.
- mem_write_enable  out  1  registered write strobe.
- mem_write_data  out  DW  registered write data.
- mem_in_data  in  DW  memory read data, valid one cycle after the address cycle.

Behaviour:
- Reset (async, rst_n=0): all of the following are 0 while reset is held and on release:
  - mem_addr, mem_byte_enable, mem_write_enable, mem_write_data
  - a_ack, b_ack, a_rvalid, b_rvalid
  - starve_cnt and the tag pipeline
- Arbitration in cycle N, combinational:
  - grant_b = b_req & (~a_req | starve_cnt == STARVE_LIMIT); otherwise grant_a = a_req.
  - No requests means an idle cycle.
- Issue, at the end of cycle N:
  - For the granted port: mem_addr, mem_byte_enable, mem_write_data and mem_write_enable are loaded from that port.
  - The matching ack is high for cycle N+1.
  - On an idle cycle: mem_write_enable=0, mem_byte_enable=0, and mem_addr/mem_write_data hold their values.
- Write: mem_write_enable is high for exactly cycle N+1, one strobe per ack.
- Read latency:
  - The address is presented in N+1 and memory returns data in N+2.
  - The matching rvalid is high for exactly cycle N+2; rdata = mem_in_data.
- Tag pipeline: 2 stages, each {valid, port}. A stage is valid only for reads. A write produces no rvalid.
- Back-to-back: a new grant is allowed every cycle. A requester that keeps req high after ack is treated as a new request.
  - Requesters must drop or update req in the ack cycle.
  - The arbiter does not deduplicate requests.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments each cycle b_req=1 and B is not granted.
  - Clears when B is granted or when b_req=0.
- Forced B grant: happens in the cycle starve_cnt==STARVE_LIMIT. A sees a_wait=1 for that cycle.
- Simultaneous events: both requests with starve_cnt<STARVE_LIMIT grants A. Exactly one ack per cycle is ever high.
- Reset mid-operation: in-flight tags are discarded; no rvalid or ack appears after rst_n rises until a new grant.
- a_wait/b_wait are purely combinational from the current req and the grant, with no registered state beyond starve_cnt.

Decomposition:
- Package scp_mem_pkg holds:
  - PORT_A/PORT_B index constants
  - the tag struct {valid, port}
  - the AW/DW defaults
  - the STARVE_LIMIT default
- One natural sub-module, mem_arb_tag_pipe: the 2-stage read-return tag shift register producing a_rvalid/b_rvalid.
- Arbitration and the starvation counter stay in mem_arbiter.

Test Plan:
- Single read: after reset, a_req=1, a_addr=0x0100, a_we=0 in cycle 0 -> a_ack in cycle 1 with mem_addr=0x0100 and mem_write_enable=0; a_rvalid in cycle 2 with rdata equal to memory[0x0100]; b_rvalid stays 0.
- Byte write: b_req=1, b_addr=0x2001, b_byte=1, b_we=1, b_wdata=0x00AB with a_req=0 -> cycle 1 shows b_ack=1, mem_addr=0x2001, mem_byte_enable=1, mem_write_enable=1, mem_write_data=0x00AB; cycle 2 shows mem_write_enable=0 and no rvalid.
- Contention: a_req and b_req held high with STARVE_LIMIT=4 -> A is granted for 4 cycles, B is forced in the 5th (b_wait=0, a_wait=1), then the pattern repeats; exactly one ack per cycle.
- Pipelined reads: alternate A and B reads at 0x10, 0x20, 0x30 on consecutive cycles -> rvalid alternates a, b, a in cycles 2, 3, 4, each aligned with the matching mem_in_data.
- Reset mid-flight: issue an A read in cycle 0 and assert rst_n=0 in cycle 1 -> all outputs 0 immediately; no a_rvalid after release; starve_cnt=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter slice.
// Holds the port index constants, the read-return tag type, the default
// address/data widths and starvation limit, and the grant debug enum.
package scp_mem_pkg;

  localparam int AW_DEF           = 16;
  localparam int DW_DEF           = 16;
  localparam int STARVE_LIMIT_DEF = 4;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // One entry of the read-return tag pipeline.
  typedef struct packed {
    logic valid;  // a read was issued in this slot
    logic port;   // PORT_A or PORT_B
  } tag_t;

  typedef logic [3:0] starve_cnt_t;

  // Debug view of the arbitration decision for the current cycle.
  typedef enum logic [1:0] {
    GRANT_IDLE = 2'd0,
    GRANT_A    = 2'd1,
    GRANT_B    = 2'd2
  } grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester and memory-side signals for mem_arbiter.
// slave  : arbiter view (requests in, waits/acks/rvalids and memory bus out).
// master : requester/memory-model view (the opposite directions).
// Handshake: a requester holds *_req with its address/data stable until
// *_ack; *_ack is a one-cycle pulse meaning the access was issued. Keeping
// *_req high after *_ack issues a fresh access. Reads return via *_rvalid
// one cycle after the ack, with the data on rdata.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          a_req;
  logic [AW-1:0] a_addr;
  logic          a_byte;
  logic          a_we;
  logic [DW-1:0] a_wdata;
  logic          a_wait;
  logic          a_ack;
  logic          a_rvalid;

  logic          b_req;
  logic [AW-1:0] b_addr;
  logic          b_byte;
  logic          b_we;
  logic [DW-1:0] b_wdata;
  logic          b_wait;
  logic          b_ack;
  logic          b_rvalid;

  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_byte_enable;
  logic          mem_write_enable;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_in_data;

  modport slave (
    input  a_req, a_addr, a_byte, a_we, a_wdata,
    output a_wait, a_ack, a_rvalid,
    input  b_req, b_addr, b_byte, b_we, b_wdata,
    output b_wait, b_ack, b_rvalid,
    output rdata, mem_addr, mem_byte_enable, mem_write_enable, mem_write_data,
    input  mem_in_data
  );

  modport master (
    output a_req, a_addr, a_byte, a_we, a_wdata,
    input  a_wait, a_ack, a_rvalid,
    output b_req, b_addr, b_byte, b_we, b_wdata,
    input  b_wait, b_ack, b_rvalid,
    input  rdata, mem_addr, mem_byte_enable, mem_write_enable, mem_write_data,
    output mem_in_data
  );
endinterface

// File: rtl/mem_arb_tag_pipe.sv
// Two-stage read-return tag shift register.
// tag_in   : {valid, port} of the access granted this cycle (valid only for reads)
// a_rvalid : registered, high in the cycle memory returns A's read data
// b_rvalid : registered, high in the cycle memory returns B's read data
// Stage 0 covers the address cycle; the rvalid flops form stage 1.
module mem_arb_tag_pipe
  import scp_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output logic a_rvalid,
  output logic b_rvalid
);

  tag_t stage0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage0   <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      stage0   <= tag_in;
      a_rvalid <= stage0.valid && (stage0.port == PORT_A);
      b_rvalid <= stage0.valid && (stage0.port == PORT_B);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single pipelined synchronous memory port.
// Port A (CPU) has fixed priority; port B (DMA/video) is forced through after
// STARVE_LIMIT consecutive denied request cycles.
// clk, rst_n      : clock, asynchronous active-low reset
// bus (slave)     : requester ports A/B and the registered memory bus
// dbg_starve_cnt  : current starvation count for port B
// dbg_grant       : arbitration decision of the current cycle
module mem_arbiter
  import scp_mem_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output starve_cnt_t   dbg_starve_cnt,
  output grant_e        dbg_grant
);

  localparam starve_cnt_t LIMIT = starve_cnt_t'(STARVE_LIMIT);

  logic          grant_a;
  logic          grant_b;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_byte;
  logic          sel_we;
  tag_t          tag_in;
  starve_cnt_t   starve_cnt;

  // A wins unless it is idle or B has waited long enough.
  always_comb begin
    grant_b   = bus.b_req && (!bus.a_req || (starve_cnt == LIMIT));
    grant_a   = bus.a_req && !grant_b;
    sel_addr  = grant_b ? bus.b_addr  : bus.a_addr;
    sel_wdata = grant_b ? bus.b_wdata : bus.a_wdata;
    sel_byte  = grant_b ? bus.b_byte  : bus.a_byte;
    sel_we    = grant_b ? bus.b_we    : bus.a_we;
    tag_in.valid = (grant_a || grant_b) && !sel_we;
    tag_in.port  = grant_b ? PORT_B : PORT_A;
    dbg_grant    = grant_b ? GRANT_B : (grant_a ? GRANT_A : GRANT_IDLE);
  end

  assign bus.a_wait      = bus.a_req && !grant_a;
  assign bus.b_wait      = bus.b_req && !grant_b;
  assign bus.rdata       = bus.mem_in_data;
  assign dbg_starve_cnt  = starve_cnt;

  // Memory bus issue. On idle cycles the strobes drop but address and
  // write data keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_addr         <= '0;
      bus.mem_byte_enable  <= 1'b0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_write_data   <= '0;
      bus.a_ack            <= 1'b0;
      bus.b_ack            <= 1'b0;
    end else begin
      bus.a_ack <= grant_a;
      bus.b_ack <= grant_b;
      if (grant_a || grant_b) begin
        bus.mem_addr         <= sel_addr;
        bus.mem_byte_enable  <= sel_byte;
        bus.mem_write_enable <= sel_we;
        bus.mem_write_data   <= sel_wdata;
      end else begin
        bus.mem_byte_enable  <= 1'b0;
        bus.mem_write_enable <= 1'b0;
      end
    end
  end

  // Saturating count of consecutive cycles B asked and was refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!bus.b_req || grant_b) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + starve_cnt_t'(1);
    end
  end

  mem_arb_tag_pipe u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .tag_in   (tag_in),
    .a_rvalid (bus.a_rvalid),
    .b_rvalid (bus.b_rvalid)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Stimulus pushes expected issues and read
// returns into queues; a negedge monitor pops and compares whenever an ack
// or rvalid appears. The memory model returns mem_addr ^ 16'h5A5A one cycle
// after the address cycle.
module tb_mem_arbiter;
  import scp_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();
  starve_cnt_t dbg_starve_cnt;
  grant_e      dbg_grant;

  mem_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .dbg_starve_cnt (dbg_starve_cnt),
    .dbg_grant      (dbg_grant)
  );

  // Memory model
  always @(posedge clk) bus.mem_in_data <= bus.mem_addr ^ 16'h5A5A;

  int n_vec = 0;
  int n_err = 0;

  // {port, byte, we, addr, wdata}
  logic [34:0] exp_ack_q[$];
  // {port, rdata}
  logic [16:0] exp_rd_q[$];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic [15:0] addr, input logic byt,
                       input logic we, input logic [15:0] wdata);
    bus.a_req = req; bus.a_addr = addr; bus.a_byte = byt; bus.a_we = we; bus.a_wdata = wdata;
  endtask

  task automatic set_b(input logic req, input logic [15:0] addr, input logic byt,
                       input logic we, input logic [15:0] wdata);
    bus.b_req = req; bus.b_addr = addr; bus.b_byte = byt; bus.b_we = we; bus.b_wdata = wdata;
  endtask

  task automatic idle();
    set_a(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    set_b(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic check_reset_outs(input string name);
    check(name, {2'b0, bus.a_ack, bus.b_ack, bus.a_rvalid, bus.b_rvalid,
                 bus.mem_write_enable, bus.mem_byte_enable, bus.mem_addr, bus.mem_write_data}, 40'h0);
    check({name, "_starve"}, 40'(dbg_starve_cnt), 40'h0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [34:0] ea;
    logic [16:0] er;
    if (rst_n) begin
      if (bus.a_ack || bus.b_ack) begin
        check("ack_onehot", 40'(bus.a_ack & bus.b_ack), 40'h0);
        if (exp_ack_q.size() == 0) begin
          check("ack_unexpected", 40'({bus.a_ack, bus.b_ack}), 40'h0);
        end else begin
          ea = exp_ack_q.pop_front();
          check("ack_issue", 40'({bus.b_ack, bus.mem_byte_enable, bus.mem_write_enable,
                                  bus.mem_addr, bus.mem_write_data}), 40'(ea));
        end
      end else begin
        check("idle_strobes", 40'({bus.mem_write_enable, bus.mem_byte_enable}), 40'h0);
      end
      if (bus.a_rvalid || bus.b_rvalid) begin
        check("rvalid_onehot", 40'(bus.a_rvalid & bus.b_rvalid), 40'h0);
        if (exp_rd_q.size() == 0) begin
          check("rvalid_unexpected", 40'({bus.a_rvalid, bus.b_rvalid}), 40'h0);
        end else begin
          er = exp_rd_q.pop_front();
          check("read_return", 40'({bus.b_rvalid, bus.rdata}), 40'(er));
        end
      end
    end
  end

  // Contention pattern: bit k set means B wins cycle k.
  logic [9:0] b_pat;

  initial begin
    b_pat = 10'b10_0001_0000;
    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    check_reset_outs("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Single A read
    set_a(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000);
    exp_ack_q.push_back({PORT_A, 1'b0, 1'b0, 16'h0100, 16'h0000});
    exp_rd_q.push_back({PORT_A, 16'h5B5A});
    @(negedge clk);
    check("single_read_wait", 40'({bus.a_wait, bus.b_wait}), 40'h0);
    step();
    idle();
    repeat (3) step();

    // B byte write
    set_b(1'b1, 16'h2001, 1'b1, 1'b1, 16'h00AB);
    exp_ack_q.push_back({PORT_B, 1'b1, 1'b1, 16'h2001, 16'h00AB});
    @(negedge clk);
    check("bwrite_wait", 40'({bus.a_wait, bus.b_wait}), 40'h0);
    step();
    idle();
    @(negedge clk);
    check("bwrite_fields", 40'({bus.b_ack, bus.mem_addr, bus.mem_write_data}),
          40'({1'b1, 16'h2001, 16'h00AB}));
    step();
    @(negedge clk);
    check("bwrite_addr_hold", 40'({bus.mem_write_enable, bus.mem_addr}), 40'({1'b0, 16'h2001}));
    repeat (2) step();

    // Contention: A and B both held for 10 cycles
    for (int k = 0; k < 10; k++) begin
      set_a(1'b1, 16'h0A00, 1'b0, 1'b0, 16'h0000);
      set_b(1'b1, 16'h0B00, 1'b0, 1'b0, 16'h0000);
      if (b_pat[k]) begin
        exp_ack_q.push_back({PORT_B, 1'b0, 1'b0, 16'h0B00, 16'h0000});
        exp_rd_q.push_back({PORT_B, 16'h515A});
      end else begin
        exp_ack_q.push_back({PORT_A, 1'b0, 1'b0, 16'h0A00, 16'h0000});
        exp_rd_q.push_back({PORT_A, 16'h505A});
      end
      @(negedge clk);
      check("contend_wait", 40'({bus.a_wait, bus.b_wait}), b_pat[k] ? 40'h2 : 40'h1);
      check("contend_starve", 40'(dbg_starve_cnt), 40'(k % 5));
      step();
    end
    idle();
    repeat (4) step();

    // Pipelined reads A, B, A on consecutive cycles
    set_a(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000);
    exp_ack_q.push_back({PORT_A, 1'b0, 1'b0, 16'h0010, 16'h0000});
    exp_rd_q.push_back({PORT_A, 16'h5A4A});
    step();
    idle();
    set_b(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000);
    exp_ack_q.push_back({PORT_B, 1'b0, 1'b0, 16'h0020, 16'h0000});
    exp_rd_q.push_back({PORT_B, 16'h5A7A});
    step();
    idle();
    set_a(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000);
    exp_ack_q.push_back({PORT_A, 1'b0, 1'b0, 16'h0030, 16'h0000});
    exp_rd_q.push_back({PORT_A, 16'h5A6A});
    step();
    idle();
    repeat (4) step();

    // Reset mid-flight: A read granted (B refused, starve_cnt -> 1), then reset
    set_a(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000);
    set_b(1'b1, 16'h0050, 1'b0, 1'b0, 16'h0000);
    step();
    rst_n = 1'b0;
    idle();
    #1;
    check_reset_outs("reset_midflight");
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check_reset_outs("after_release");

    check("ack_q_empty", 40'(exp_ack_q.size()), 40'h0);
    check("rd_q_empty", 40'(exp_rd_q.size()), 40'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
